// File: rtl/weight_fifo_in_ctrl.sv
// weight_fifo_in_ctrl: fill-side controller for the weight FIFO bank.
// Steers a lane-serial valid/ready weight stream into FIFO_WIDTH lane FIFOs
// (lane-major within a row, row by row), pulses drain_req once the bank holds
// FIFO_WIDTH*FIFO_DEPTH words, then waits for drain_done before refilling.
// Optional feature: define WEIGHT_FIFO_IN_FLUSH_EN to add the flush input and
// the registered fifo_clr output, which abandon the current fill or drain wait.
module weight_fifo_in_ctrl #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [FIFO_WIDTH-1:0] fifo_push,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  drain_req,
  input  logic                  drain_done,
  output logic                  busy
`ifdef WEIGHT_FIFO_IN_FLUSH_EN
  ,
  input  logic                  flush,
  output logic                  fifo_clr
`endif
);

  localparam int LANE_W = $clog2(FIFO_WIDTH);
  localparam int ROW_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(FIFO_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [LANE_W-1:0]     lane_cnt_q, lane_cnt_d;
  logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
  logic [FIFO_WIDTH-1:0] fifo_push_q, fifo_push_d;
  logic [DATA_WIDTH-1:0] fifo_wdata_q, fifo_wdata_d;
  logic                  drain_req_q, drain_req_d;
`ifdef WEIGHT_FIFO_IN_FLUSH_EN
  logic                  fifo_clr_q, fifo_clr_d;
`endif

  // Next-state, counter and registered-output computation; a push and the
  // drain request are prepared here so they appear the cycle after the handshake.
  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    row_cnt_d    = row_cnt_q;
    fifo_push_d  = '0;
    fifo_wdata_d = fifo_wdata_q;
    drain_req_d  = 1'b0;
`ifdef WEIGHT_FIFO_IN_FLUSH_EN
    fifo_clr_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = FILL;
          lane_cnt_d = '0;
          row_cnt_d  = '0;
        end
      end
      FILL: begin
        if (in_valid) begin
          fifo_push_d[lane_cnt_q] = 1'b1;
          fifo_wdata_d            = in_data;
          if (lane_cnt_q == LANE_LAST) begin
            lane_cnt_d = '0;
            if (row_cnt_q == ROW_LAST) begin
              state_d     = FULL;
              row_cnt_d   = '0;
              drain_req_d = 1'b1;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
            end
          end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (drain_done) begin
          state_d    = load_start ? FILL : IDLE;
          lane_cnt_d = '0;
          row_cnt_d  = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        lane_cnt_d = '0;
        row_cnt_d  = '0;
      end
    endcase
`ifdef WEIGHT_FIFO_IN_FLUSH_EN
    if (flush) begin
      state_d      = IDLE;
      lane_cnt_d   = '0;
      row_cnt_d    = '0;
      fifo_push_d  = '0;
      fifo_wdata_d = fifo_wdata_q;
      drain_req_d  = 1'b0;
      fifo_clr_d   = 1'b1;
    end
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      lane_cnt_q   <= '0;
      row_cnt_q    <= '0;
      fifo_push_q  <= '0;
      fifo_wdata_q <= '0;
      drain_req_q  <= 1'b0;
`ifdef WEIGHT_FIFO_IN_FLUSH_EN
      fifo_clr_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      row_cnt_q    <= row_cnt_d;
      fifo_push_q  <= fifo_push_d;
      fifo_wdata_q <= fifo_wdata_d;
      drain_req_q  <= drain_req_d;
`ifdef WEIGHT_FIFO_IN_FLUSH_EN
      fifo_clr_q   <= fifo_clr_d;
`endif
    end
  end

  assign in_ready   = (state_q == FILL);
  assign busy       = (state_q != IDLE);
  assign fifo_push  = fifo_push_q;
  assign fifo_wdata = fifo_wdata_q;
  assign drain_req  = drain_req_q;
`ifdef WEIGHT_FIFO_IN_FLUSH_EN
  assign fifo_clr   = fifo_clr_q;
`endif

endmodule
